// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam int         DIGITS  = 4;

endpackage

// File: rtl/hex_scan_timer.sv
// Slot timer for the hex display scanner: tracks blank/drive phase, the
// digit index and the in-slot counter, and raises the frame snapshot strobe.
// With HEX_SCAN_DIM_EN defined it also exports the low counter nibble used
// by the dimming gate.
module hex_scan_timer
    import hex_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
`ifdef HEX_SCAN_DIM_EN
    output logic [3:0] cnt_lo_o,
`endif
    output phase_e     phase_o,
    output logic [1:0] idx_o,
    output logic       snap_o
);

    localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    phase_e           phase_q, phase_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: a low enable rewinds to the start of a frame.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            phase_d = BLANK;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else if (phase_q == BLANK) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BLANK_LAST) begin
                phase_d = DRIVE;
            end
        end else begin
            if (cnt_q == DIGIT_LAST) begin
                cnt_d   = '0;
                phase_d = BLANK;
                idx_d   = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= BLANK;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Snapshot strobe marks the first cycle of each frame; held off during reset.
    always_comb begin
        snap_o = en_i && !rst_i && (phase_q == BLANK) && (idx_q == 2'd0) && (cnt_q == '0);
    end

    assign phase_o = phase_q;
    assign idx_o   = idx_q;

`ifdef HEX_SCAN_DIM_EN
    logic [CNT_W+3:0] cnt_ext;
    assign cnt_ext  = {4'b0000, cnt_q};
    assign cnt_lo_o = cnt_ext[3:0];
`endif

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed 4-digit seven-segment driver. Patterns are snapshotted
// once per frame so a register write can never tear a frame; each digit slot
// opens with a blanking gap to suppress ghosting.
// Optional feature macro: HEX_SCAN_DIM_EN adds brightness_i PWM dimming.
module hex_display_scan
    import hex_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] hex0_i,
    input  logic [7:0] hex1_i,
    input  logic [7:0] hex2_i,
    input  logic [7:0] hex3_i,
`ifdef HEX_SCAN_DIM_EN
    input  logic [3:0] brightness_i,
`endif
    output logic [7:0] seg_o,
    output logic [3:0] an_o,
    output logic       frame_o
);

    phase_e     phase;
    logic [1:0] idx;
    logic       snap_stb;
    logic       lit;

    logic [DIGITS-1:0][7:0] snap_q, snap_d;

`ifdef HEX_SCAN_DIM_EN
    logic [3:0] cnt_lo;
`endif

    hex_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
`ifdef HEX_SCAN_DIM_EN
        .cnt_lo_o (cnt_lo),
`endif
        .phase_o  (phase),
        .idx_o    (idx),
        .snap_o   (snap_stb)
    );

    // Capture all four patterns together at the frame strobe; clear when disabled.
    always_comb begin
        snap_d = snap_q;
        if (!en_i) begin
            snap_d = {DIGITS{SEG_OFF}};
        end else if (snap_stb) begin
            snap_d = {hex3_i, hex2_i, hex1_i, hex0_i};
        end
    end

    // Snapshot registers with synchronous reset to all segments off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_q <= {DIGITS{SEG_OFF}};
        end else begin
            snap_q <= snap_d;
        end
    end

    // Output mux: only registered state feeds the pins; en_i darkens immediately.
    always_comb begin
        lit = en_i && (phase == DRIVE);
`ifdef HEX_SCAN_DIM_EN
        lit = lit && (cnt_lo <= brightness_i);
`endif
        seg_o = SEG_OFF;
        an_o  = AN_OFF;
        if (lit) begin
            seg_o = snap_q[idx];
            an_o  = ~(4'b0001 << idx);
        end
    end

    assign frame_o = snap_stb;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_hex_display_scan;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [7:0] hex0_i, hex1_i, hex2_i, hex3_i;
    logic [7:0] seg_o;
    logic [3:0] an_o;
    logic       frame_o;
`ifdef HEX_SCAN_DIM_EN
    logic [3:0] brightness_i;
`endif

    int errors = 0;
    int checks = 0;
    int bexp   = 15;
    logic [7:0] exp_pat [4];

    always #5 clk_i = ~clk_i;

    hex_display_scan #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .hex0_i       (hex0_i),
        .hex1_i       (hex1_i),
        .hex2_i       (hex2_i),
        .hex3_i       (hex3_i),
`ifdef HEX_SCAN_DIM_EN
        .brightness_i (brightness_i),
`endif
        .seg_o        (seg_o),
        .an_o         (an_o),
        .frame_o      (frame_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for a cycle counted from the latest frame start.
    task automatic check_cycle(input string tag, input int rel);
        int          off;
        int          slot;
        logic        lit;
        logic [7:0]  seg_e;
        logic [3:0]  an_e;
        off  = rel % 8;
        slot = (rel / 8) % 4;
        lit  = (off >= 2) && (off <= bexp);
        seg_e = lit ? exp_pat[slot] : 8'hFF;
        an_e  = lit ? ~(4'b0001 << slot) : 4'hF;
        check($sformatf("%s c%0d frame", tag, rel), frame_o, (rel % 32) == 0);
        check($sformatf("%s c%0d seg", tag, rel), seg_o, seg_e);
        check($sformatf("%s c%0d an", tag, rel), an_o, an_e);
    endtask

    task automatic check_dark(input string tag);
        check({tag, " seg"}, seg_o, 8'hFF);
        check({tag, " an"}, an_o, 4'hF);
        check({tag, " frame"}, frame_o, 1'b0);
    endtask

    task automatic run(input string tag, input int from, input int to);
        for (int r = from; r <= to; r++) begin
            @(negedge clk_i);
            check_cycle(tag, r);
            @(posedge clk_i);
            #1;
        end
    endtask

    // Hold reset for n checked cycles; returns at the start of frame cycle 0.
    task automatic do_reset(input int n);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            check_dark($sformatf("reset c%0d", i));
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i  = 1'b1;
        en_i   = 1'b1;
        hex0_i = 8'hC0;
        hex1_i = 8'hF9;
        hex2_i = 8'hA4;
        hex3_i = 8'hB0;
`ifdef HEX_SCAN_DIM_EN
        brightness_i = 4'd15;
`endif
        exp_pat[0] = 8'hC0;
        exp_pat[1] = 8'hF9;
        exp_pat[2] = 8'hA4;
        exp_pat[3] = 8'hB0;

        // Reset/idle, then basic scan with a tear-free hex0 update at cycle 12
        do_reset(5);
        run("scan", 0, 11);
        hex0_i = 8'h80;
        run("scan", 12, 31);
        exp_pat[0] = 8'h80;
        run("scan", 32, 79);

        // Enable drop at cycle 20 for 3 cycles
        hex0_i = 8'hC0;
        exp_pat[0] = 8'hC0;
        do_reset(2);
        run("pre_en", 0, 19);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_dark($sformatf("en_low c%0d", i));
            @(posedge clk_i);
            #1;
        end
        en_i = 1'b1;
        run("en_back", 0, 40);

        // Mid-frame reset during idx 2 drive: lit until the edge, then restart
        do_reset(2);
        run("pre_rst", 0, 19);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_cycle("rst_hi", 20);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        run("post_rst", 0, 40);

`ifdef HEX_SCAN_DIM_EN
        // Dimmed: lit only for in-slot counts 2..3
        brightness_i = 4'd3;
        bexp = 3;
        do_reset(2);
        run("dim", 0, 40);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
